mux16_drain_sched: RTL and testbench
====================================

# mux16_drain_sched

Sequencer that drains up to 16 parallel lane results through the shared 16-to-1 lane multiplexer into a single valid/ready output stream. On `start` it latches a lane-enable mask and drives the mux select across the enabled lanes in ascending order, skipping disabled lanes, one beat per cycle under back-pressure. It sits between the transpose-convolution accumulator bank, which feeds the mux inputs, and the downstream write-back or stream interface.

## Interface
- `DATA_WIDTH`, default 16: width of the mux output and stream data (signed).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a drain; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; returns the block to IDLE.
- `lane_mask`  in  16  lanes to drain, bit i = lane i; latched on accepted `start`.
- `mux_sel`  out  4  select driven to the 16-to-1 mux.
- `mux_data`  in  DATA_WIDTH  mux `data_out`, combinational from `mux_sel`.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream ready.
- `m_data`  out  DATA_WIDTH  registered lane value.
- `m_lane`  out  4  lane index of the current beat.
- `m_last`  out  1  current beat is the final enabled lane.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the drain completes.

## Operation
- States: IDLE, DRAIN, FLUSH.
- **IDLE:** `start & !abort` loads `pend <= lane_mask`.
  - If `lane_mask` is nonzero, go to DRAIN.
  - If `lane_mask` is zero, pulse `done` next cycle and stay in IDLE. `busy` does not assert.
- `mux_sel` is the index of the lowest set bit of `pend` (combinational priority encode). It is 0 when `pend` is 0.
- **Load condition:** `pend != 0 && (!m_valid || m_ready)`. On load:
  - `m_data <= mux_data`
  - `m_lane <= mux_sel`
  - `m_last <= (pend with bit mux_sel cleared) == 0`
  - clear bit `mux_sel` in `pend`
  - `m_valid <= 1`
- If `m_valid & m_ready` and the load condition is false, then `m_valid <= 0`.
- **DRAIN to FLUSH** when the last bit of `pend` is cleared.
- **FLUSH to IDLE** on `m_valid & m_ready & m_last`. `done` pulses the following cycle and `busy` drops in the same cycle as `done`.
- `m_data`, `m_lane` and `m_last` hold steady while `m_valid & !m_ready`. Output handshake rule: no beat is dropped or duplicated.
- `start` while busy is ignored and does not alter `pend`.
- **Abort** in any state, at the next edge:
  - `pend <= 0`, `m_valid <= 0`, state goes to IDLE.
  - No `done` pulse.
  - Abort wins over a simultaneous `start` or handshake.
- Upstream holds all mux inputs stable from the `start` cycle until `done`. The block does not re-sample lanes.
- Data passes unmodified. No arithmetic is applied; width is `DATA_WIDTH` signed throughout.

## Timing
- **Reset values (async, `rst_n` = 0):** state IDLE, `pend` 0, `mux_sel` 0, `m_valid` 0, `m_data` 0, `m_lane` 0, `m_last` 0, `busy` 0, `done` 0.
- **Reset mid-drain:** all outputs return to their reset values immediately.
- **Latency:** `start` sampled at edge E0. First beat has `m_valid = 1` after edge E1. With `m_ready` held at 1, beats follow every cycle, so N enabled lanes take N cycles.
- `done` is high for exactly the one cycle after the edge on which the `m_last` beat is accepted.
- **Full throughput:** with `m_ready` constantly high, the load and the accept of the previous beat occur on the same edge.
- `mux_sel` changes only on the edge after a load. The `mux_data` seen at load is the value for the registered `pend` state.

## Test plan
- **Full mask, no stall.** `lane_mask` = 0xFFFF, lane i = i*3−20, `m_ready` = 1. Required: 16 consecutive beats with `m_lane` 0..15 and `m_data` −20, −17, …, 25; `m_last` only on lane 15; `done` one cycle after it; `busy` high for 17 cycles.
- **Sparse mask with back-pressure.** Mask 0x8421, `m_ready` toggling 1,0,0,1,… Required: beats lanes 0, 5, 10, 15 in order; data held stable during stalls; no duplicated or dropped beat; `m_last` on lane 15.
- **Zero mask.** `start` with mask 0x0000. Required: `done` pulse one cycle later, `m_valid` never asserts, `busy` stays 0.
- **Abort mid-drain.** Mask 0x00FF, `abort` asserted after the third accepted beat. Required: `m_valid` = 0 next cycle, state IDLE, no `done`. A subsequent `start` with mask 0x0003 drains lanes 0 and 1 normally.
- **Start while busy.** Mask 0x000F drain running; `start` pulsed with mask 0xF000. Required: ignored, only lanes 0–3 output.
- **Async reset.** `rst_n` pulled low mid-cycle during a stalled beat. Required: all outputs 0 immediately. After release, `start` with mask 0x0001 gives a single beat with `m_lane` 0 and `m_last` 1.

Source files
------------

// File: rtl/mux16_drain_sched.sv
// rtl/mux16_drain_sched.sv - drains enabled lanes of a 16-to-1 mux into a valid/ready stream
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   start, abort    begin a drain (sampled in IDLE) / cancel back to IDLE
//   lane_mask       lanes to drain, latched on accepted start
//   mux_sel         select driven to the shared lane mux
//   mux_data        mux output, combinational from mux_sel
//   m_valid/m_ready output stream handshake
//   m_data, m_lane, m_last  registered beat payload
//   busy, done      drain in progress / one-cycle completion pulse
module mux16_drain_sched #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [15:0]                  lane_mask,
    output logic [3:0]                   mux_sel,
    input  logic signed [DATA_WIDTH-1:0] mux_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [DATA_WIDTH-1:0] m_data,
    output logic [3:0]                   m_lane,
    output logic                         m_last,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pend;
    logic [15:0] pend_clr;
    logic        load;
    logic        accept;
    logic        start_ok;

    // Lowest pending lane wins; scanning downward leaves the lowest index last.
    always_comb begin
        mux_sel = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pend[i]) begin
                mux_sel = 4'(i);
            end
        end
    end

    assign pend_clr = pend & ~(16'd1 << mux_sel);
    // Output register refills whenever it is empty or being emptied this edge.
    assign load     = (pend != 16'd0) && (!m_valid || m_ready);
    assign accept   = m_valid && m_ready;
    assign start_ok = (state == IDLE) && start && !abort;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && lane_mask != 16'd0) begin
                        state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    if (load && pend_clr == 16'd0) begin
                        state_next = FLUSH;
                    end
                end
                FLUSH: begin
                    if (accept && m_last) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= 16'd0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_lane  <= 4'd0;
            m_last  <= 1'b0;
            done    <= 1'b0;
        end else if (abort) begin
            pend    <= 16'd0;
            m_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            // An empty mask completes immediately without ever going busy.
            done <= (start_ok && lane_mask == 16'd0) ||
                    (state == FLUSH && accept && m_last);
            if (start_ok) begin
                pend <= lane_mask;
            end else if (load) begin
                pend <= pend_clr;
            end
            if (load) begin
                m_data  <= mux_data;
                m_lane  <= mux_sel;
                m_last  <= (pend_clr == 16'd0);
                m_valid <= 1'b1;
            end else if (accept) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux16_drain_sched.sv
// tb/tb_mux16_drain_sched.sv - directed self-checking bench for mux16_drain_sched
module tb_mux16_drain_sched;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [15:0]        lane_mask = 16'd0;
    logic [3:0]         mux_sel;
    logic signed [15:0] mux_data;
    logic               m_valid;
    logic               m_ready = 1'b1;
    logic signed [15:0] m_data;
    logic [3:0]         m_lane;
    logic               m_last;
    logic               busy;
    logic               done;

    logic signed [15:0] lanes [16];
    int errors = 0;
    int checks = 0;

    assign mux_data = lanes[mux_sel];

    always #5 clk = ~clk;

    mux16_drain_sched #(.DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .lane_mask(lane_mask), .mux_sel(mux_sel), .mux_data(mux_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_lane(m_lane), .m_last(m_last), .busy(busy), .done(done)
    );

    // Stimulus only: pulse start for one edge, return at the negedge after it.
    task automatic pulse_start(input logic [15:0] m);
        start = 1'b1;
        lane_mask = m;
        @(negedge clk);
        start = 1'b0;
        lane_mask = 16'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 16'sd0) begin errors++; $display("FAIL reset_m_data got=%0d exp=0", m_data); end
        checks++; if (m_lane !== 4'd0) begin errors++; $display("FAIL reset_m_lane got=%0d exp=0", m_lane); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (mux_sel !== 4'd0) begin errors++; $display("FAIL reset_mux_sel got=%0d exp=0", mux_sel); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle valid=%b busy=%b exp=0,0", m_valid, busy); end
    endtask

    task automatic test_full_mask();
        int beat = 0, busy_cnt = 0, last_cnt = 0;
        logic done_seen = 1'b0, prev_last_acc = 1'b0;
        m_ready = 1'b1;
        pulse_start(16'hFFFF);
        for (int c = 0; c < 40 && !done_seen; c++) begin
            if (c == 0) begin
                checks++; if (m_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL full_first_cycle valid=%b busy=%b exp=0,1", m_valid, busy); end
            end
            if (c >= 1 && c <= 16) begin
                checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL full_no_gap cycle=%0d valid=%b exp=1", c, m_valid); end
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_seen = 1'b1;
                checks++; if (!prev_last_acc || busy !== 1'b0) begin errors++; $display("FAIL full_done_timing prev_last_acc=%b busy=%b exp=1,0", prev_last_acc, busy); end
            end
            prev_last_acc = m_valid && m_ready && m_last;
            if (m_valid && m_ready) begin
                checks++; if (m_lane !== 4'(beat) || m_data !== 16'(beat * 3 - 20)) begin errors++; $display("FAIL full_beat%0d lane=%0d data=%0d exp lane=%0d data=%0d", beat, m_lane, m_data, beat, beat * 3 - 20); end
                checks++; if (m_last !== (beat == 15)) begin errors++; $display("FAIL full_last beat=%0d got=%b exp=%b", beat, m_last, beat == 15); end
                if (m_last) last_cnt++;
                beat++;
            end
            @(negedge clk);
        end
        checks++; if (!done_seen) begin errors++; $display("FAIL full_done_timeout got=0 exp=1"); end
        checks++; if (beat != 16 || last_cnt != 1) begin errors++; $display("FAIL full_counts beats=%0d lasts=%0d exp=16,1", beat, last_cnt); end
        checks++; if (busy_cnt != 17) begin errors++; $display("FAIL full_busy_cycles got=%0d exp=17", busy_cnt); end
        checks++; if (done !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL full_after done=%b valid=%b exp=0,0", done, m_valid); end
    endtask

    task automatic test_sparse_backpressure();
        logic [3:0] exp_lane [4];
        int beat = 0;
        logic done_seen = 1'b0, prev_last_acc = 1'b0, held = 1'b0;
        logic signed [15:0] hd = 16'sd0;
        logic [3:0] hl = 4'd0;
        logic hlast = 1'b0;
        exp_lane[0] = 4'd0; exp_lane[1] = 4'd5; exp_lane[2] = 4'd10; exp_lane[3] = 4'd15;
        m_ready = 1'b1;
        pulse_start(16'h8421);
        for (int c = 0; c < 60 && !done_seen; c++) begin
            m_ready = (c % 4 == 0) || (c % 4 == 3);
            if (held) begin
                checks++; if (m_valid !== 1'b1 || m_data !== hd || m_lane !== hl || m_last !== hlast) begin errors++; $display("FAIL sparse_hold cycle=%0d valid=%b lane=%0d data=%0d exp valid=1 lane=%0d data=%0d", c, m_valid, m_lane, m_data, hl, hd); end
            end
            if (done) begin
                done_seen = 1'b1;
                checks++; if (!prev_last_acc) begin errors++; $display("FAIL sparse_done_timing prev_last_acc=%b exp=1", prev_last_acc); end
            end
            held = m_valid && !m_ready;
            hd = m_data; hl = m_lane; hlast = m_last;
            prev_last_acc = m_valid && m_ready && m_last;
            if (m_valid && m_ready) begin
                if (beat < 4) begin
                    checks++; if (m_lane !== exp_lane[beat] || m_data !== 16'(int'(exp_lane[beat]) * 3 - 20) || m_last !== (beat == 3)) begin errors++; $display("FAIL sparse_beat%0d lane=%0d data=%0d last=%b exp lane=%0d data=%0d last=%b", beat, m_lane, m_data, m_last, exp_lane[beat], int'(exp_lane[beat]) * 3 - 20, beat == 3); end
                end
                beat++;
            end
            @(negedge clk);
        end
        m_ready = 1'b1;
        checks++; if (!done_seen || beat != 4) begin errors++; $display("FAIL sparse_count done=%b beats=%0d exp=1,4", done_seen, beat); end
    endtask

    task automatic test_zero_mask();
        m_ready = 1'b1;
        pulse_start(16'h0000);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL zero_pulse done=%b busy=%b valid=%b exp=1,0,0", done, busy, m_valid); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL zero_after done=%b busy=%b valid=%b exp=0,0,0", done, busy, m_valid); end
    endtask

    task automatic test_abort();
        int acc = 0, beat = 0;
        logic done_seen = 1'b0;
        m_ready = 1'b1;
        pulse_start(16'h00FF);
        for (int c = 0; c < 20 && acc < 3; c++) begin
            if (m_valid && m_ready) acc++;
            @(negedge clk);
        end
        checks++; if (acc != 3) begin errors++; $display("FAIL abort_accepts got=%0d exp=3", acc); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle valid=%b busy=%b done=%b exp=0,0,0", m_valid, busy, done); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (m_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_quiet cycle=%0d valid=%b done=%b exp=0,0", c, m_valid, done); end
        end
        pulse_start(16'h0003);
        for (int c = 0; c < 20 && !done_seen; c++) begin
            if (done) done_seen = 1'b1;
            if (m_valid && m_ready) begin
                checks++; if (m_lane !== 4'(beat) || m_data !== 16'(beat * 3 - 20) || m_last !== (beat == 1)) begin errors++; $display("FAIL abort_restart_beat%0d lane=%0d data=%0d last=%b exp lane=%0d data=%0d last=%b", beat, m_lane, m_data, m_last, beat, beat * 3 - 20, beat == 1); end
                beat++;
            end
            @(negedge clk);
        end
        checks++; if (!done_seen || beat != 2) begin errors++; $display("FAIL abort_restart_count done=%b beats=%0d exp=1,2", done_seen, beat); end
    endtask

    task automatic test_start_busy();
        int beat = 0;
        logic done_seen = 1'b0;
        m_ready = 1'b1;
        pulse_start(16'h000F);
        for (int c = 0; c < 20 && !done_seen; c++) begin
            if (c == 2) begin start = 1'b1; lane_mask = 16'hF000; end
            else begin start = 1'b0; lane_mask = 16'h0; end
            if (done) done_seen = 1'b1;
            if (m_valid && m_ready) begin
                checks++; if (m_lane !== 4'(beat) || m_last !== (beat == 3)) begin errors++; $display("FAIL busy_start_beat%0d lane=%0d last=%b exp lane=%0d last=%b", beat, m_lane, m_last, beat, beat == 3); end
                beat++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (!done_seen || beat != 4) begin errors++; $display("FAIL busy_start_count done=%b beats=%0d exp=1,4", done_seen, beat); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL busy_start_quiet cycle=%0d valid=%b busy=%b exp=0,0", c, m_valid, busy); end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        logic done_seen = 1'b0;
        int beat = 0;
        m_ready = 1'b0;
        pulse_start(16'h000F);
        @(negedge clk);
        checks++; if (m_valid !== 1'b1 || m_data !== -16'sd20 || mux_sel !== 4'd1) begin errors++; $display("FAIL areset_stall valid=%b data=%0d sel=%0d exp=1,-20,1", m_valid, m_data, mux_sel); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || m_data !== 16'sd0 || m_lane !== 4'd0 || m_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mux_sel !== 4'd0) begin errors++; $display("FAIL areset_outputs valid=%b data=%0d lane=%0d last=%b busy=%b done=%b sel=%0d exp all 0", m_valid, m_data, m_lane, m_last, busy, done, mux_sel); end
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        pulse_start(16'h0001);
        for (int c = 0; c < 10 && !done_seen; c++) begin
            if (done) done_seen = 1'b1;
            if (m_valid && m_ready) begin
                checks++; if (m_lane !== 4'd0 || m_last !== 1'b1 || m_data !== -16'sd20) begin errors++; $display("FAIL areset_single lane=%0d last=%b data=%0d exp=0,1,-20", m_lane, m_last, m_data); end
                beat++;
            end
            @(negedge clk);
        end
        checks++; if (!done_seen || beat != 1) begin errors++; $display("FAIL areset_single_count done=%b beats=%0d exp=1,1", done_seen, beat); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) lanes[i] = 16'(i * 3 - 20);
        test_reset();
        test_full_mask();
        test_sparse_backpressure();
        test_zero_mask();
        test_abort();
        test_start_busy();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
